hex_display_ctrl: RTL and testbench

Parametrised multi-digit 7-segment display controller for the board's active-low HEX outputs. It generalises the fixed two-digit decoder top to `DIGITS` digits. It adds registered value capture, leading-zero suppression, a per-digit blank mask, and timed display modes (blink, scroll, lamp test) driven by an internal tick prescaler. It sits between application logic and the HEX pins, and instantiates the existing 4-bit hex-to-segment decoder once per digit.

---
 rtl/hex_display_pkg.sv | 15 +
 rtl/decoder_7seg_table.sv | 28 ++
 rtl/hex_display_ctrl.sv | 129 ++++++++++++
 tb/tb_hex_display_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the multi-digit HEX display controller.
package hex_display_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_LAMP   = 2'd3
  } disp_mode_t;

  // Active-low segment images for a dark digit and a fully lit digit.
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_ALL_ON = 7'h00;

endpackage

// File: rtl/decoder_7seg_table.sv
// 4-bit hex to 7-segment decoder, positive logic, segment order gfedcba.
module decoder_7seg_table (
  input  logic [3:0] d,
  output logic [6:0] y
);

  always_comb begin
    case (d)
      4'h0:    y = 7'h3F;
      4'h1:    y = 7'h06;
      4'h2:    y = 7'h5B;
      4'h3:    y = 7'h4F;
      4'h4:    y = 7'h66;
      4'h5:    y = 7'h6D;
      4'h6:    y = 7'h7D;
      4'h7:    y = 7'h07;
      4'h8:    y = 7'h7F;
      4'h9:    y = 7'h6F;
      4'hA:    y = 7'h77;
      4'hB:    y = 7'h7C;
      4'hC:    y = 7'h39;
      4'hD:    y = 7'h5E;
      4'hE:    y = 7'h79;
      default: y = 7'h71;
    endcase
  end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low 7-segment controller: value capture, leading-zero
// blanking, per-digit mask and tick-driven blink/scroll/lamp-test modes.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [1:0]            mode,
  input  logic                  lz_suppress,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [7*DIGITS-1:0]   hex_n,
  output logic                  tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int OFF_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(DIGITS - 1);

  disp_mode_t              mode_e;
  logic [4*DIGITS-1:0]     disp_val;
  logic [CNT_W-1:0]        cnt;
  logic                    phase;
  logic [OFF_W-1:0]        offset;
  logic [OFF_W-1:0]        eff_off;
  logic [3:0]              rot [DIGITS];
  logic [6:0]              seg [DIGITS];
  logic [DIGITS-1:0]       lz_blank;
  logic                    lz_on;
  logic [7*DIGITS-1:0]     img;

  assign mode_e  = disp_mode_t'(mode);
  // A load restarts the period, so it also swallows a coinciding wrap pulse.
  assign tick    = (cnt == CNT_LAST) && !load;
  assign eff_off = (mode_e == MODE_SCROLL) ? offset : '0;
  assign lz_on   = lz_suppress && (mode_e == MODE_STATIC || mode_e == MODE_BLINK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_val <= '0;
      cnt      <= '0;
      phase    <= 1'b0;
      offset   <= '0;
    end else begin
      if (load) begin
        disp_val <= value;
      end

      if (load || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (load || mode_e != MODE_BLINK) begin
        phase <= 1'b0;
      end else if (tick) begin
        phase <= ~phase;
      end

      if (load || mode_e != MODE_SCROLL) begin
        offset <= '0;
      end else if (tick) begin
        offset <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
      end
    end
  end

  // Nibble k lands on physical digit (k + offset) mod DIGITS: content rotates left.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      rot[i] = '0;
      for (int k = 0; k < DIGITS; k++) begin
        automatic int s = k + int'(eff_off);
        if (s >= DIGITS) s = s - DIGITS;
        if (s == i) rot[i] = disp_val[4*k +: 4];
      end
    end
  end

  // Zero run from the top digit downward; digit 0 always stays visible.
  always_comb begin
    automatic logic still = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      still       = still && (disp_val[4*i +: 4] == 4'h0);
      lz_blank[i] = still;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    decoder_7seg_table u_dec (
      .d (rot[g]),
      .y (seg[g])
    );
  end

  always_comb begin
    img = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (mode_e == MODE_LAMP) begin
        img[7*i +: 7] = SEG_ALL_ON;
      end else if (blank_mask[i]) begin
        img[7*i +: 7] = SEG_BLANK;
      end else if (mode_e == MODE_BLINK && phase) begin
        img[7*i +: 7] = SEG_BLANK;
      end else if (lz_on && lz_blank[i]) begin
        img[7*i +: 7] = SEG_BLANK;
      end else begin
        img[7*i +: 7] = ~seg[i];
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_n <= '1;
    end else begin
      hex_n <= img;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with DIGITS=6, TICK_DIV=4.
module tb_hex_display_ctrl;

  localparam int DIGITS   = 6;
  localparam int TICK_DIV = 4;
  localparam logic [6:0] DK = 7'h7F;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [23:0] value;
  logic [1:0]  mode;
  logic        lz_suppress;
  logic [5:0]  blank_mask;
  logic [41:0] hex_n;
  logic        tick;

  int total = 0;
  int bad   = 0;

  hex_display_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .value       (value),
    .mode        (mode),
    .lz_suppress (lz_suppress),
    .blank_mask  (blank_mask),
    .hex_n       (hex_n),
    .tick        (tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] lit(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    return ~p;
  endfunction

  function automatic logic [41:0] pk(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [41:0] exp;
    reset_n = 1'b0; load = 1'b0; value = '0; mode = 2'd0;
    lz_suppress = 1'b0; blank_mask = '0;
    step(2);
    exp = '1;
    total++; if (hex_n !== exp) begin bad++; $display("FAIL reset_dark: hex_n=%h want %h", hex_n, exp); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: tick=%b want 0", tick); end
    reset_n = 1'b1;
    step(1);
    exp = pk(lit(0), lit(0), lit(0), lit(0), lit(0), lit(0));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL reset_first_edge: hex_n=%h want %h", hex_n, exp); end
  endtask

  task automatic test_static();
    logic [41:0] exp;
    mode = 2'd0; lz_suppress = 1'b0; value = 24'h00A05F; load = 1'b1;
    step(1);
    load = 1'b0;
    exp = pk(lit(0), lit(0), lit(0), lit(0), lit(0), lit(0));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL static_latency: hex_n=%h want %h", hex_n, exp); end
    step(1);
    exp = pk(lit(0), lit(0), lit(4'hA), lit(0), lit(5), lit(4'hF));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL static_img: hex_n=%h want %h", hex_n, exp); end
    lz_suppress = 1'b1;
    step(1);
    exp = pk(DK, DK, lit(4'hA), lit(0), lit(5), lit(4'hF));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL static_lz: hex_n=%h want %h", hex_n, exp); end
    value = 24'h000000; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    exp = pk(DK, DK, DK, DK, DK, lit(0));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL static_lz_zero: hex_n=%h want %h", hex_n, exp); end
    lz_suppress = 1'b0;
  endtask

  task automatic test_blink();
    logic [41:0] img1, img2, dark;
    img1 = pk(lit(1), lit(2), lit(3), lit(4), lit(5), lit(6));
    img2 = pk(lit(6), lit(5), lit(4), lit(3), lit(2), lit(1));
    dark = '1;
    mode = 2'd1; value = 24'h123456; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    total++; if (hex_n !== img1) begin bad++; $display("FAIL blink_on0: hex_n=%h want %h", hex_n, img1); end
    step(2);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL blink_tick: tick=%b want 1", tick); end
    step(1);
    total++; if (hex_n !== img1) begin bad++; $display("FAIL blink_on_last: hex_n=%h want %h", hex_n, img1); end
    step(1);
    total++; if (hex_n !== dark) begin bad++; $display("FAIL blink_off0: hex_n=%h want %h", hex_n, dark); end
    step(4);
    total++; if (hex_n !== img1) begin bad++; $display("FAIL blink_on1: hex_n=%h want %h", hex_n, img1); end
    step(4);
    total++; if (hex_n !== dark) begin bad++; $display("FAIL blink_off1: hex_n=%h want %h", hex_n, dark); end
    value = 24'h654321; load = 1'b1;
    step(1);
    load = 1'b0;
    total++; if (hex_n !== dark) begin bad++; $display("FAIL blink_load_edge: hex_n=%h want %h", hex_n, dark); end
    step(1);
    total++; if (hex_n !== img2) begin bad++; $display("FAIL blink_load_restore: hex_n=%h want %h", hex_n, img2); end
    step(3);
    total++; if (hex_n !== img2) begin bad++; $display("FAIL blink_after_load_on: hex_n=%h want %h", hex_n, img2); end
    step(1);
    total++; if (hex_n !== dark) begin bad++; $display("FAIL blink_after_load_off: hex_n=%h want %h", hex_n, dark); end
  endtask

  task automatic test_load_tick();
    logic [41:0] img;
    img = pk(lit(1), lit(2), lit(3), lit(4), lit(5), lit(6));
    mode = 2'd1; value = 24'h123456; load = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL lt_wrap_pending: tick=%b want 1", tick); end
    load = 1'b1;
    #1;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL lt_tick_suppressed: tick=%b want 0", tick); end
    step(1);
    load = 1'b0;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL lt_cnt_restart: tick=%b want 0", tick); end
    step(1);
    total++; if (hex_n !== img) begin bad++; $display("FAIL lt_phase_kept: hex_n=%h want %h", hex_n, img); end
    step(1);
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL lt_no_early_tick: tick=%b want 0", tick); end
    step(1);
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL lt_next_tick: tick=%b want 1", tick); end
  endtask

  task automatic test_scroll();
    logic [41:0] s0, s1, s2, exp;
    s0 = pk(lit(0), lit(1), lit(2), lit(3), lit(4), lit(5));
    s1 = pk(lit(1), lit(2), lit(3), lit(4), lit(5), lit(0));
    s2 = pk(lit(2), lit(3), lit(4), lit(5), lit(0), lit(1));
    mode = 2'd2; lz_suppress = 1'b1; value = 24'h012345; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    total++; if (hex_n !== s0) begin bad++; $display("FAIL scroll_off0: hex_n=%h want %h", hex_n, s0); end
    step(4);
    total++; if (hex_n !== s1) begin bad++; $display("FAIL scroll_off1: hex_n=%h want %h", hex_n, s1); end
    step(4);
    total++; if (hex_n !== s2) begin bad++; $display("FAIL scroll_off2: hex_n=%h want %h", hex_n, s2); end
    step(16);
    total++; if (hex_n !== s0) begin bad++; $display("FAIL scroll_wrap: hex_n=%h want %h", hex_n, s0); end
    step(4);
    total++; if (hex_n !== s1) begin bad++; $display("FAIL scroll_wrap_off1: hex_n=%h want %h", hex_n, s1); end
    mode = 2'd0;
    step(1);
    exp = pk(DK, lit(1), lit(2), lit(3), lit(4), lit(5));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL scroll_to_static: hex_n=%h want %h", hex_n, exp); end
    lz_suppress = 1'b0;
  endtask

  task automatic test_mask_lamp();
    logic [41:0] exp;
    mode = 2'd3; blank_mask = 6'b000010; lz_suppress = 1'b0;
    value = 24'h00A05F; load = 1'b1;
    step(1);
    load = 1'b0;
    exp = '0;
    total++; if (hex_n !== exp) begin bad++; $display("FAIL lamp_load: hex_n=%h want %h", hex_n, exp); end
    step(1);
    total++; if (hex_n !== exp) begin bad++; $display("FAIL lamp_mask: hex_n=%h want %h", hex_n, exp); end
    mode = 2'd0;
    step(1);
    exp = pk(lit(0), lit(0), lit(4'hA), lit(0), DK, lit(4'hF));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL mask_static: hex_n=%h want %h", hex_n, exp); end
    blank_mask = '0;
    step(1);
  endtask

  task automatic test_async_reset();
    logic [41:0] exp;
    reset_n = 1'b0;
    #2;
    exp = '1;
    total++; if (hex_n !== exp) begin bad++; $display("FAIL async_dark: hex_n=%h want %h", hex_n, exp); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL async_tick: tick=%b want 0", tick); end
    #2;
    reset_n = 1'b1;
    step(1);
    exp = pk(lit(0), lit(0), lit(0), lit(0), lit(0), lit(0));
    total++; if (hex_n !== exp) begin bad++; $display("FAIL async_val_cleared: hex_n=%h want %h", hex_n, exp); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_blink();
    test_load_tick();
    test_scroll();
    test_mask_lamp();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
